// File: rtl/la_pkg.sv
// la_pkg: shared definitions for the logic-analyser capture engine.
// Trigger mode codes, FSM state encoding and the pre-length clamp.
package la_pkg;

  localparam logic [2:0] LA_MODE_LOW  = 3'd0;
  localparam logic [2:0] LA_MODE_HIGH = 3'd1;
  localparam logic [2:0] LA_MODE_RISE = 3'd2;
  localparam logic [2:0] LA_MODE_FALL = 3'd3;
  localparam logic [2:0] LA_MODE_EDGE = 3'd4;
  localparam logic [2:0] LA_MODE_IMM  = 3'd5;
  localparam logic [2:0] LA_MODE_PAT  = 3'd6;
  localparam logic [2:0] LA_MODE_ALT  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT,
    ST_POST,
    ST_DONE
  } la_state_e;

  function automatic logic [31:0] la_clamp(
    input logic [31:0] len,
    input logic [31:0] lim
  );
    return (len > lim) ? lim : len;
  endfunction

endpackage

// File: rtl/la_trig_eval.sv
// la_trig_eval: combinational trigger decision for one sample.
// cur/prev: current and previous sample; mode, channel_sel,
// pattern, mask: trigger setup; first: first sample after arm;
// trig: trigger condition true for this sample.
module la_trig_eval
  import la_pkg::*;
#(
  parameter int CH_W  = 8,
  parameter int SEL_W = 3
) (
  input  logic [CH_W-1:0]  cur,
  input  logic [CH_W-1:0]  prev,
  input  logic [2:0]       mode,
  input  logic [SEL_W-1:0] channel_sel,
  input  logic [CH_W-1:0]  pattern,
  input  logic [CH_W-1:0]  mask,
  input  logic             first,
  output logic             trig
);

  logic ch_ok;
  logic c_cur;
  logic c_prv;
  logic edge_ok;

  // A channel number with no matching bit leaves ch_ok low,
  // so the single-channel modes can never fire on it.
  always_comb begin
    ch_ok = 1'b0;
    c_cur = 1'b0;
    c_prv = 1'b0;
    for (int i = 0; i < CH_W; i++) begin
      if (channel_sel == SEL_W'(i)) begin
        ch_ok = 1'b1;
        c_cur = cur[i];
        c_prv = prev[i];
      end
    end
  end

  // prev is stale on the first sample after arm.
  assign edge_ok = ch_ok & ~first;

  always_comb begin
    trig = 1'b0;
    unique case (mode)
      LA_MODE_LOW:  trig = ch_ok & ~c_cur;
      LA_MODE_HIGH: trig = ch_ok & c_cur;
      LA_MODE_RISE: trig = edge_ok & c_cur & ~c_prv;
      LA_MODE_FALL: trig = edge_ok & ~c_cur & c_prv;
      LA_MODE_EDGE: trig = edge_ok & (c_cur ^ c_prv);
      LA_MODE_IMM:  trig = 1'b1;
      LA_MODE_PAT:  trig = ((cur ^ pattern) & mask) == '0;
      LA_MODE_ALT:  trig = 1'b1;
    endcase
  end

endmodule

// File: rtl/la_pretrig_capture.sv
// la_pretrig_capture: pre-trigger logic-analyser capture engine.
// Samples data_in on sample_en into a circular RAM buffer.
// Inputs: clk_50M, rst (async high), sample_en, arm, abort,
//   mode_sel, channel_sel, pattern, mask, pre_len, data_in.
// Outputs: wr_addr/wr_data/wren RAM port, trig_addr, busy, done.
module la_pretrig_capture
  import la_pkg::*;
#(
  parameter int CH_W   = 8,
  parameter int ADDR_W = 17,
  parameter int SEL_W  = 3
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              arm,
  input  logic              abort,
  input  logic [2:0]        mode_sel,
  input  logic [SEL_W-1:0]  channel_sel,
  input  logic [CH_W-1:0]   pattern,
  input  logic [CH_W-1:0]   mask,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [CH_W-1:0]   data_in,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CH_W-1:0]   wr_data,
  output logic              wren,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done
);

  localparam logic [31:0] LIM =
    32'((64'd1 << ADDR_W) - 64'd1);
  localparam logic [ADDR_W-1:0] TOP = '1;

  la_state_e state;

  logic [CH_W-1:0]   r1;
  logic [CH_W-1:0]   r2;
  logic [CH_W-1:0]   r3;
  logic              s_vld;
  logic              first;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] post;
  logic [ADDR_W-1:0] pre_lat;
  logic [ADDR_W-1:0] pre_c;
  logic [ADDR_W-1:0] post_init;
  logic              trig;
  logic              in_cap;
  logic              wr_go;

  assign pre_c = ADDR_W'(la_clamp(32'(pre_len), LIM));

  // Words left after the trigger sample: DEPTH-1-pre.
  assign post_init = TOP - pre_lat;

  assign in_cap = (state == ST_PRE) |
                  (state == ST_WAIT) |
                  (state == ST_POST);
  assign wr_go  = s_vld & in_cap;

  la_trig_eval #(
    .CH_W  (CH_W),
    .SEL_W (SEL_W)
  ) u_trig (
    .cur         (r2),
    .prev        (r3),
    .mode        (mode_sel),
    .channel_sel (channel_sel),
    .pattern     (pattern),
    .mask        (mask),
    .first       (first),
    .trig        (trig)
  );

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      s_vld     <= 1'b0;
      first     <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
      post      <= '0;
      pre_lat   <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wren      <= 1'b0;
      trig_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      s_vld <= sample_en;
      if (sample_en) begin
        r1 <= data_in;
        r2 <= r1;
        r3 <= r2;
      end
      wren <= 1'b0;

      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        if (wr_go) begin
          wren    <= 1'b1;
          wr_data <= r2;
          wr_addr <= ptr;
          ptr     <= ptr + 1'b1;
          first   <= 1'b0;
        end

        unique case (state)
          ST_IDLE, ST_DONE: begin
            if (arm) begin
              ptr     <= '0;
              cnt     <= '0;
              pre_lat <= pre_c;
              first   <= 1'b1;
              busy    <= 1'b1;
              done    <= 1'b0;
              state   <= (pre_c == '0) ? ST_WAIT : ST_PRE;
            end
          end
          ST_PRE: begin
            if (s_vld) begin
              cnt <= cnt + 1'b1;
              if (cnt + 1'b1 == pre_lat) begin
                state <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (s_vld && trig) begin
              trig_addr <= ptr;
              post      <= post_init;
              if (post_init == '0) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_POST;
              end
            end
          end
          ST_POST: begin
            if (s_vld) begin
              post <= post - 1'b1;
              if (post == 1) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_la_pretrig_capture.sv
// tb_la_pretrig_capture: scoreboard bench for the capture engine.
// Reference model works per captured sample index, not per cycle.
module tb_la_pretrig_capture;

  localparam int CH_W   = 8;
  localparam int ADDR_W = 4;
  localparam int SEL_W  = 3;
  localparam int DEPTH  = 16;

  logic              clk_50M = 1'b0;
  logic              rst = 1'b1;
  logic              sample_en = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic [2:0]        mode_sel = '0;
  logic [SEL_W-1:0]  channel_sel = '0;
  logic [CH_W-1:0]   pattern = '0;
  logic [CH_W-1:0]   mask = '0;
  logic [ADDR_W-1:0] pre_len = '0;
  logic [CH_W-1:0]   data_in = '0;
  logic [ADDR_W-1:0] wr_addr;
  logic [CH_W-1:0]   wr_data;
  logic              wren;
  logic [ADDR_W-1:0] trig_addr;
  logic              busy;
  logic              done;

  la_pretrig_capture #(
    .CH_W   (CH_W),
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) dut (
    .clk_50M     (clk_50M),
    .rst         (rst),
    .sample_en   (sample_en),
    .arm         (arm),
    .abort       (abort),
    .mode_sel    (mode_sel),
    .channel_sel (channel_sel),
    .pattern     (pattern),
    .mask        (mask),
    .pre_len     (pre_len),
    .data_in     (data_in),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wren        (wren),
    .trig_addr   (trig_addr),
    .busy        (busy),
    .done        (done)
  );

  always #10 clk_50M = ~clk_50M;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] hist[$];
  int         checks = 0;
  int         errors = 0;

  bit cap_on    = 0;
  bit trig_seen = 0;
  bit exp_busy  = 0;
  bit exp_done  = 0;
  int j         = 0;
  int m_pre     = 0;
  int last_j    = 0;
  int exp_trig  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, req);
    end
  endtask

  always @(negedge clk_50M) begin
    if (!rst && wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wren_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), e.addr);
        chk("wr_data", 32'(wr_data), e.data);
      end
    end
  end

  function automatic bit ref_trig(input logic [7:0] cur,
                                  input logic [7:0] prv,
                                  input bit first);
    int c;
    bit a;
    bit b;
    c = int'(channel_sel);
    if (mode_sel <= 3'd4 && c >= CH_W) return 1'b0;
    a = cur[c];
    b = prv[c];
    case (mode_sel)
      3'd0: return !a;
      3'd1: return a;
      3'd2: return !first && a && !b;
      3'd3: return !first && !a && b;
      3'd4: return !first && (a != b);
      3'd6: return (cur & mask) == (pattern & mask);
      default: return 1'b1;
    endcase
  endfunction

  // One captured sample with index j goes to address j mod DEPTH.
  task automatic model_step(input logic [7:0] cur,
                            input logic [7:0] prv);
    exp_q.push_back('{j % DEPTH, int'(cur)});
    if (!trig_seen && j >= m_pre &&
        ref_trig(cur, prv, j == 0)) begin
      trig_seen = 1;
      exp_trig  = j % DEPTH;
      last_j    = j + DEPTH - 1 - m_pre;
    end
    if (trig_seen && j == last_j) begin
      cap_on   = 0;
      exp_busy = 0;
      exp_done = 1;
    end
    j++;
  endtask

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic strike(input logic [7:0] d,
                        input int gap,
                        input bit kill);
    logic [7:0] cur;
    logic [7:0] prv;
    int n;
    n   = hist.size();
    cur = (n >= 1) ? hist[n-1] : 8'h00;
    prv = (n >= 2) ? hist[n-2] : 8'h00;
    hist.push_back(d);
    if (kill) begin
      cap_on   = 0;
      exp_busy = 0;
      exp_done = 0;
    end else if (cap_on) begin
      model_step(cur, prv);
    end
    data_in   = d;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    if (kill) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    repeat (gap) tick();
  endtask

  task automatic do_arm(input int pre);
    if (!cap_on) begin
      cap_on    = 1;
      j         = 0;
      trig_seen = 0;
      m_pre     = (pre > DEPTH - 1) ? DEPTH - 1 : pre;
      exp_busy  = 1;
      exp_done  = 0;
    end
    pre_len = ADDR_W'(pre);
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
  endtask

  task automatic do_abort();
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    cap_on   = 0;
    exp_busy = 0;
    exp_done = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
  endtask

  task automatic check_status(input string tag);
    repeat (3) tick();
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_trig_addr"}, 32'(trig_addr), exp_trig);
    chk({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  task automatic setup(input int m, input int ch,
                       input logic [7:0] p,
                       input logic [7:0] mk);
    mode_sel    = 3'(m);
    channel_sel = SEL_W'(ch);
    pattern     = p;
    mask        = mk;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int n;

    #5;
    chk("rst_wren", 32'(wren), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_trig_addr", 32'(trig_addr), 0);
    tick();
    rst = 1'b0;
    tick();

    // Rising edge on ch0 at captured sample 9, pre 3.
    setup(2, 0, 8'h00, 8'h00);
    do_arm(3);
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom) & 8'hFE;
      d[0] = (k >= 8);
      strike(d, $urandom_range(0, 2), 0);
    end
    check_status("rise");
    chk("rise_trig9", 32'(trig_addr), 32'd9);

    // Masked pattern: 8'h15 is the first low-nibble match.
    setup(6, 0, 8'hA5, 8'h0F);
    do_arm(2);
    strike(8'h00, 1, 0);
    strike(8'h15, 0, 0);
    strike(8'h35, 2, 0);
    for (int k = 0; k < 15; k++)
      strike(8'($urandom), $urandom_range(0, 2), 0);
    check_status("pat");
    chk("pat_trig2", 32'(trig_addr), 32'd2);

    // Immediate trigger with no pre-history.
    setup(5, 0, 8'h00, 8'h00);
    do_arm(0);
    for (int k = 0; k < 18; k++)
      strike(8'($urandom), $urandom_range(0, 1), 0);
    check_status("imm");
    chk("imm_trig0", 32'(trig_addr), 32'd0);

    // Abort in POST with a sample in flight.
    setup(5, 0, 8'h00, 8'h00);
    do_arm(2);
    for (int k = 0; k < 5; k++)
      strike(8'($urandom), 1, 0);
    strike(8'hC3, 0, 1);
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_done", 32'(done), 32'd0);
    check_status("kill");

    // Re-arm after abort.
    do_arm(15);
    for (int k = 0; k < 17; k++)
      strike(8'($urandom), 0, 0);
    check_status("rearm");

    // Reset mid-WAIT, arm held during reset.
    setup(1, 7, 8'h00, 8'h00);
    do_arm(2);
    for (int k = 0; k < 4; k++)
      strike(8'($urandom) & 8'h7F, 1, 0);
    repeat (2) tick();
    rst = 1'b1;
    #2;
    chk("mid_rst_wren", 32'(wren), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 0);
    chk("mid_rst_wr_data", 32'(wr_data), 0);
    chk("mid_rst_trig", 32'(trig_addr), 0);
    arm = 1'b1;
    repeat (2) tick();
    chk("rst_arm_busy", 32'(busy), 0);
    rst = 1'b0;
    arm = 1'b0;
    hist.delete();
    exp_q.delete();
    cap_on   = 0;
    exp_busy = 0;
    exp_done = 0;
    exp_trig = 0;
    tick();

    // Full pre-history, stable input: no edge, pointer wraps.
    setup(4, 3, 8'h00, 8'h00);
    do_arm(15);
    for (int k = 0; k < 24; k++) begin
      strike(8'h08, $urandom_range(0, 1), 0);
      if (k == 18) begin
        tick();
        do_arm(0);
      end
    end
    check_status("hold");
    do_abort();

    for (int r = 0; r < 10; r++) begin
      setup($urandom_range(0, 7), $urandom_range(0, 7),
            8'($urandom), 8'($urandom));
      do_arm($urandom_range(0, 15));
      n = $urandom_range(10, 45);
      for (int k = 0; k < n; k++) begin
        d = ($urandom_range(0, 3) == 0) ? pattern : 8'($urandom);
        strike(d, $urandom_range(0, 2), 0);
      end
      check_status("rand");
      if (exp_busy) do_abort();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
